// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: FSM state encoding and settle counter width.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/truth_table_sweeper_bin2gray.sv
// Combinational binary to reflected Gray code converter.
module bin2gray #(
  parameter int W = 3
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine for a 1-output combinational DUT: drives every input vector,
// holds it SETTLE+1 cycles, samples dut_f, and counts mismatches against EXPECTED.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                       N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]     EXPECTED = 8'b1110_1000,
  parameter int                       SETTLE   = 1,
  parameter bit                       GRAY     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_f,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err,
  output logic            err_seen,
  output logic            smp_valid,
  output logic [N_IN-1:0] smp_vec,
  output logic            smp_f
);

  localparam logic [N_IN-1:0]  IDX_LAST  = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam state_e           VEC_ST    = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN:0]     errc_q, errc_d;
  logic [N_IN-1:0]   ferr_q, ferr_d;
  logic              seen_q, seen_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              smpv_q, smpv_d;
  logic [N_IN-1:0]   smpvec_q, smpvec_d;
  logic              smpf_q, smpf_d;

  logic [N_IN-1:0]   idx_inc;
  logic [N_IN-1:0]   gray_w;
  logic [N_IN-1:0]   vec_step;
  logic              mism;

  assign idx_inc = idx_q + 1'b1;

  bin2gray #(.W(N_IN)) u_bin2gray (
    .bin_i  (idx_inc),
    .gray_o (gray_w)
  );

  assign vec_step = GRAY ? gray_w : idx_inc;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    errc_d   = errc_q;
    ferr_d   = ferr_q;
    seen_d   = seen_q;
    done_d   = done_q;
    pass_d   = pass_q;
    smpv_d   = 1'b0;
    smpvec_d = smpvec_q;
    smpf_d   = smpf_q;
    mism     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d = VEC_ST;
          idx_d   = '0;
          vec_d   = '0;
          cnt_d   = '0;
          errc_d  = '0;
          ferr_d  = '0;
          seen_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // Aborted sample leaves counters and the sample stream untouched.
          state_d = ST_IDLE;
          vec_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          mism     = (dut_f != EXPECTED[vec_q]);
          smpv_d   = 1'b1;
          smpvec_d = vec_q;
          smpf_d   = dut_f;
          if (mism) begin
            errc_d = errc_q + 1'b1;
            if (!seen_q) begin
              ferr_d = vec_q;
              seen_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (errc_d == '0);
          end else begin
            state_d = VEC_ST;
            idx_d   = idx_inc;
            vec_d   = vec_step;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      vec_q    <= '0;
      cnt_q    <= '0;
      errc_q   <= '0;
      ferr_q   <= '0;
      seen_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      smpv_q   <= 1'b0;
      smpvec_q <= '0;
      smpf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      errc_q   <= errc_d;
      ferr_q   <= ferr_d;
      seen_q   <= seen_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      smpv_q   <= smpv_d;
      smpvec_q <= smpvec_d;
      smpf_q   <= smpf_d;
    end
  end

  assign vec_out   = vec_q;
  assign busy      = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = errc_q;
  assign first_err = ferr_q;
  assign err_seen  = seen_q;
  assign smp_valid = smpv_q;
  assign smp_vec   = smpvec_q;
  assign smp_f     = smpf_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: three sweeper configurations, each driving a behavioural DUT with injectable faults.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s[3];
  logic       abort_s[3];
  logic       dut_f_s[3];
  logic [15:0] fault[3];

  int nin_p[3]    = '{3, 3, 4};
  int settle_p[3] = '{1, 0, 2};
  int gray_p[3]   = '{0, 1, 0};

  wire [2:0] vec0, vec1, fe0, fe1, sv0, sv1;
  wire [3:0] vec2, fe2, sv2, ec0, ec1;
  wire [4:0] ec2;
  wire       busy_w[3], done_w[3], pass_w[3], seen_w[3], smpv_w[3], smpf_w[3];

  logic [7:0] vec_a[3], fe_a[3], svec_a[3];
  logic [8:0] ec_a[3];

  always_comb begin
    vec_a[0] = 8'(vec0); vec_a[1] = 8'(vec1); vec_a[2] = 8'(vec2);
    fe_a[0]  = 8'(fe0);  fe_a[1]  = 8'(fe1);  fe_a[2]  = 8'(fe2);
    svec_a[0] = 8'(sv0); svec_a[1] = 8'(sv1); svec_a[2] = 8'(sv2);
    ec_a[0]  = 9'(ec0);  ec_a[1]  = 9'(ec1);  ec_a[2]  = 9'(ec2);
  end

  truth_table_sweeper u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .dut_f(dut_f_s[0]),
    .vec_out(vec0), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(ec0),
    .first_err(fe0), .err_seen(seen_w[0]), .smp_valid(smpv_w[0]), .smp_vec(sv0), .smp_f(smpf_w[0])
  );

  truth_table_sweeper #(.SETTLE(0), .GRAY(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .dut_f(dut_f_s[1]),
    .vec_out(vec1), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(ec1),
    .first_err(fe1), .err_seen(seen_w[1]), .smp_valid(smpv_w[1]), .smp_vec(sv1), .smp_f(smpf_w[1])
  );

  truth_table_sweeper #(.N_IN(4), .EXPECTED(16'h8000), .SETTLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]), .dut_f(dut_f_s[2]),
    .vec_out(vec2), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(ec2),
    .first_err(fe2), .err_seen(seen_w[2]), .smp_valid(smpv_w[2]), .smp_vec(sv2), .smp_f(smpf_w[2])
  );

  // Intended function: 3-input majority for instances 0/1, 4-input AND for instance 2.
  function automatic logic golden(input int k, input logic [7:0] v);
    int ones;
    if (k == 2) return (v[3:0] == 4'hF);
    ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return (ones >= 2);
  endfunction

  function automatic logic [7:0] ord(input int k, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (gray_p[k] != 0) return b ^ (b >> 1);
    return b;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++)
      dut_f_s[k] = golden(k, vec_a[k]) ^ fault[k][vec_a[k][3:0]];
  end

  typedef struct packed {
    logic [1:0] k;
    logic [7:0] vec;
    logic       f;
  } smp_t;

  smp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (smpv_w[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL smp_unexpected: inst %0d vec %0h with no expected sample", k, svec_a[k]);
        end else begin
          smp_t e;
          e = exp_q.pop_front();
          chk("smp_inst", k, 32'(e.k));
          chk("smp_vec", svec_a[k], e.vec);
          chk("smp_f", smpf_w[k], e.f);
        end
      end
    end
  end

  // Queue the expected sample stream for the first ndone steps and derive the error summary.
  task automatic push_exp(input int k, input int ndone, input logic [15:0] fm,
                          output int errs, output bit seen, output int fe);
    logic [7:0] v;
    logic       f;
    smp_t       e;
    errs = 0; seen = 0; fe = 0;
    for (int i = 0; i < ndone; i++) begin
      v = ord(k, i);
      f = golden(k, v) ^ fm[v[3:0]];
      e.k = 2'(k); e.vec = v; e.f = f;
      exp_q.push_back(e);
      if (f != golden(k, v)) begin
        errs++;
        if (!seen) begin seen = 1; fe = int'(v); end
      end
    end
  endtask

  task automatic run_sweep(input int k, input logic [15:0] fm, input int abort_at, input int bsa);
    int s, nv, len, ndone, errs, fe;
    bit seen;
    s   = settle_p[k];
    nv  = 1 << nin_p[k];
    len = nv * (s + 1);
    @(negedge clk);
    fault[k] = fm;
    ndone = (abort_at >= 0) ? abort_at / (s + 1) : nv;
    push_exp(k, ndone, fm, errs, seen, fe);
    start_s[k] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      chk("vec_out", vec_a[k], ord(k, c / (s + 1)));
      chk("busy_run", busy_w[k], 1);
      chk("done_run", done_w[k], 0);
      start_s[k] = (c == bsa);
      abort_s[k] = (c == abort_at);
      if (c == abort_at) begin
        @(negedge clk);
        abort_s[k] = 1'b0;
        start_s[k] = 1'b0;
        chk("abort_busy", busy_w[k], 0);
        chk("abort_done", done_w[k], 0);
        chk("abort_pass", pass_w[k], 0);
        chk("abort_vec", vec_a[k], 0);
        chk("abort_errc", ec_a[k], errs);
        chk("abort_seen", seen_w[k], 32'(seen));
        if (seen) chk("abort_first", fe_a[k], fe);
        return;
      end
    end
    @(negedge clk);
    start_s[k] = 1'b0;
    chk("end_done", done_w[k], 1);
    chk("end_busy", busy_w[k], 0);
    chk("end_pass", pass_w[k], 32'(errs == 0));
    chk("end_errc", ec_a[k], errs);
    chk("end_seen", seen_w[k], 32'(seen));
    if (seen) chk("end_first", fe_a[k], fe);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int errs, fe, k, nv, len, ab, bs;
    bit seen;
    logic [15:0] fm;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; fault[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_vec", vec_a[i], 0);
      chk("rst_busy", busy_w[i], 0);
      chk("rst_done", done_w[i], 0);
      chk("rst_pass", pass_w[i], 0);
      chk("rst_errc", ec_a[i], 0);
      chk("rst_seen", seen_w[i], 0);
      chk("rst_smpv", smpv_w[i], 0);
    end
    rst_n = 1'b1;

    // Clean majority sweep, then abort while DONE must leave results alone.
    run_sweep(0, 16'h0000, -1, -1);
    drain();
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    @(negedge clk);
    chk("done_abort_done", done_w[0], 1);
    chk("done_abort_pass", pass_w[0], 1);

    run_sweep(0, 16'h0020, -1, -1);
    drain();
    run_sweep(1, 16'h0000, -1, -1);
    drain();
    run_sweep(0, 16'h0000, 8, -1);
    drain();
    run_sweep(0, 16'h0000, -1, -1);
    drain();

    // Reset pulsed during the SAMPLE cycle of step 2.
    @(negedge clk);
    fault[0] = '0;
    push_exp(0, 2, 16'h0000, errs, seen, fe);
    start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_w[0], 0);
    chk("arst_vec", vec_a[0], 0);
    chk("arst_done", done_w[0], 0);
    chk("arst_smpv", smpv_w[0], 0);
    @(negedge clk);
    chk("arst_smpv_after", smpv_w[0], 0);
    rst_n = 1'b1;
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    chk("sa_idle_busy", busy_w[0], 0);
    chk("sa_idle_done", done_w[0], 0);
    chk("sa_idle_vec", vec_a[0], 0);
    drain();

    run_sweep(2, 16'h8000, -1, 10);
    drain();

    for (int r = 0; r < 8; r++) begin
      k   = $urandom_range(0, 2);
      nv  = 1 << nin_p[k];
      len = nv * (settle_p[k] + 1);
      fm  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom) & 16'((1 << nv) - 1);
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      bs  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_sweep(k, fm, ab, bs);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
